prbs6_checker: RTL

- Receive-side counterpart of the 6-bit XNOR pseudo-random bit generator used by the game logic.
- Consumes a serial bit stream and seeds a local copy of the 6-bit register from it. Once seeded, it predicts each following bit and compares it with the received bit.
- Reports lock status and counts bit errors. Used for on-board self-test of the random source and of serial links that carry it.

---
 rtl/prbs6_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/prbs6_checker.sv
// Receive-side checker for the 6-bit XNOR PRBS: seeds from the stream, locks, counts bit errors.
// Optional sticky loss-of-lock flag is built when PRBS6_CHK_STICKY_EN is defined.
module prbs6_checker #(
  parameter int ERR_W     = 8,
  parameter int LOCK_GOOD = 8,
  parameter int LOSS_BAD  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  input  logic             i_in_bit,
  input  logic             i_err_clr,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [1:0]       o_state,
  output logic             o_lost_sticky
);

  typedef enum logic [1:0] {
    ST_SEED   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_LOCKED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  localparam logic [5:0]       LOCK_LAST = 6'(LOCK_GOOD - 1);
  localparam logic [3:0]       LOSS_LAST = 4'(LOSS_BAD - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           r_state, w_state_next;
  logic [5:0]       r_sh, w_sh_next;
  logic [2:0]       r_seed_cnt, w_seed_cnt_next;
  logic [5:0]       r_good_cnt, w_good_cnt_next;
  logic [3:0]       r_bad_cnt, w_bad_cnt_next;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err_pulse;
  logic             w_exp, w_match, w_err;

  assign w_exp   = ~(r_sh[4] ^ r_sh[5]);
  assign w_match = (i_in_bit == w_exp);

  always_comb begin
    w_state_next    = r_state;
    w_sh_next       = r_sh;
    w_seed_cnt_next = r_seed_cnt;
    w_good_cnt_next = r_good_cnt;
    w_bad_cnt_next  = r_bad_cnt;
    w_err           = 1'b0;
    if (r_state == ST_BAD) begin
      w_state_next    = ST_SEED;
      w_seed_cnt_next = '0;
    end else if (i_in_valid) begin
      case (r_state)
        ST_SEED: begin
          w_sh_next = {r_sh[4:0], i_in_bit};
          if (r_seed_cnt == 3'd5) begin
            w_state_next    = ST_CHECK;
            w_seed_cnt_next = '0;
            w_good_cnt_next = '0;
          end else begin
            w_seed_cnt_next = r_seed_cnt + 3'd1;
          end
        end
        ST_CHECK: begin
          w_sh_next = {r_sh[4:0], i_in_bit};
          // All-ones is the XNOR lockup state; never trust it as a seed.
          if ((r_sh == 6'h3F) || !w_match) begin
            w_state_next    = ST_SEED;
            w_seed_cnt_next = '0;
          end else if (r_good_cnt == LOCK_LAST) begin
            w_state_next    = ST_LOCKED;
            w_bad_cnt_next  = '0;
          end else begin
            w_good_cnt_next = r_good_cnt + 6'd1;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so a corrupted bit never pollutes later predictions.
          w_sh_next = {r_sh[4:0], w_exp};
          if (w_match) begin
            w_bad_cnt_next = '0;
          end else begin
            w_err = 1'b1;
            if (r_bad_cnt == LOSS_LAST) begin
              w_state_next    = ST_SEED;
              w_seed_cnt_next = '0;
              w_bad_cnt_next  = '0;
            end else begin
              w_bad_cnt_next = r_bad_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_SEED;
      r_sh        <= '0;
      r_seed_cnt  <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sh        <= w_sh_next;
      r_seed_cnt  <= w_seed_cnt_next;
      r_good_cnt  <= w_good_cnt_next;
      r_bad_cnt   <= w_bad_cnt_next;
      r_err_pulse <= w_err;
      if (i_err_clr) begin
        r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_locked    = (r_state == ST_LOCKED);
  assign o_err_pulse = r_err_pulse;
  assign o_err_cnt   = r_err_cnt;
  assign o_state     = r_state;

`ifdef PRBS6_CHK_STICKY_EN
  logic r_lost_sticky;
  logic w_lost;

  assign w_lost = i_in_valid && (r_state == ST_LOCKED) && (w_state_next == ST_SEED);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lost_sticky <= 1'b0;
    end else if (w_lost) begin
      r_lost_sticky <= 1'b1;
    end else if (i_err_clr) begin
      r_lost_sticky <= 1'b0;
    end
  end

  assign o_lost_sticky = r_lost_sticky;
`else
  assign o_lost_sticky = 1'b0;
`endif

endmodule
